// File: rtl/max_stream_packer.sv
// Packs the decimated peak byte stream little-endian into 32-bit words, appends a
// tagged trailer per sync line and buffers everything in a first-word-fall-through FIFO.
module max_stream_packer #(
    parameter int         FIFO_DEPTH  = 16,
    parameter logic [7:0] TRAILER_TAG = 8'hA5
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        sync_n,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_TRAILER
    } state_t;

    state_t      r_state, w_state_next;
    logic        r_sync_d;
    logic [31:0] r_pack, w_pack_next, w_pack_upd;
    logic [1:0]  r_lane, w_lane_next;
    logic [15:0] r_byte_cnt, w_cnt_next;
    logic        r_line_ovf, w_line_ovf_next;
    logic        r_ovf, w_ovf_next;

    logic [32:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;

    logic        w_line_end;
    logic        w_pop;
    logic        w_can_push;
    logic        w_push_req;
    logic        w_push;
    logic [32:0] w_push_word;
    logic [32:0] w_head;

    assign w_line_end = r_sync_d & ~sync_n;
    assign w_pop      = out_valid & out_ready;
    assign w_can_push = (r_count < CW'(FIFO_DEPTH)) | w_pop;
    assign w_push     = w_push_req & w_can_push;

    // Writing lane 0 starts a fresh word, so stale upper lanes are cleared and a
    // flushed partial word always carries zeros above the last byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_pack_upd[gi*8 +: 8] = (r_lane == 2'(gi)) ? data_in :
                                           (r_lane == 2'd0)   ? 8'h00   :
                                                                r_pack[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        w_state_next    = r_state;
        w_pack_next     = r_pack;
        w_lane_next     = r_lane;
        w_cnt_next      = r_byte_cnt;
        w_line_ovf_next = r_line_ovf;
        w_ovf_next      = r_ovf;
        w_push_req      = 1'b0;
        w_push_word     = '0;

        case (r_state)
            S_IDLE: begin
                if (data_valid) w_ovf_next = 1'b1;
                if (sync_n) begin
                    w_state_next    = S_RUN;
                    w_lane_next     = 2'd0;
                    w_cnt_next      = 16'd0;
                    w_line_ovf_next = 1'b0;
                end
            end
            S_RUN: begin
                if (data_valid) begin
                    w_pack_next = w_pack_upd;
                    w_lane_next = r_lane + 2'd1;
                    w_cnt_next  = (r_byte_cnt != 16'hFFFF) ? r_byte_cnt + 16'd1 : r_byte_cnt;
                    if (r_lane == 2'd3) begin
                        w_push_req  = 1'b1;
                        w_push_word = {1'b0, w_pack_upd};
                        if (!w_can_push) begin
                            w_ovf_next      = 1'b1;
                            w_line_ovf_next = 1'b1;
                        end
                    end
                end
                // Line end is judged on the lane after any byte taken this cycle.
                if (w_line_end) begin
                    w_state_next = (w_lane_next != 2'd0) ? S_FLUSH : S_TRAILER;
                end
            end
            S_FLUSH: begin
                if (data_valid) w_ovf_next = 1'b1;
                w_push_req  = 1'b1;
                w_push_word = {1'b0, r_pack};
                if (!w_can_push) begin
                    w_ovf_next      = 1'b1;
                    w_line_ovf_next = 1'b1;
                end
                w_state_next = S_TRAILER;
            end
            S_TRAILER: begin
                if (data_valid) w_ovf_next = 1'b1;
                w_push_req  = 1'b1;
                w_push_word = {1'b1, TRAILER_TAG, 7'd0, r_line_ovf, r_byte_cnt};
                if (w_can_push) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sync_d   <= 1'b0;
            r_pack     <= '0;
            r_lane     <= 2'd0;
            r_byte_cnt <= 16'd0;
            r_line_ovf <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_sync_d   <= sync_n;
            r_pack     <= w_pack_next;
            r_lane     <= w_lane_next;
            r_byte_cnt <= w_cnt_next;
            r_line_ovf <= w_line_ovf_next;
            r_ovf      <= w_ovf_next;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    // Storage kept free of reset so it maps onto plain RAM.
    always_ff @(posedge sysclk) begin
        if (w_push && !rst) r_mem[r_wr_ptr] <= w_push_word;
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? w_head[31:0] : 32'd0;
    assign out_last  = out_valid ? w_head[32] : 1'b0;
    assign ovf       = r_ovf;

endmodule
